// File: rtl/cpu_pkg.sv
// Encodings and small helpers shared by the fetch stage and the decoder.
// Target-formation helpers take only the bit fields they actually use.
package cpu_pkg;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_JR  = 2'b01;
  localparam logic [1:0] PCS_BR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] j_target(input logic [3:0]  pc_hi,
                                           input logic [25:0] idx);
    return {pc_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, register-indirect, branch, jump.
// The jr target is forced word-aligned; misalign_o flags the dropped low bits.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] inst_i,
  input  logic [31:0] rs_data_i,
  input  logic [1:0]  pc_s_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);

  logic [31:0] pc4;

  assign pc4 = pc_i + 32'd4;

  always_comb begin
    npc_o      = pc4;
    misalign_o = 1'b0;
    case (pc_s_i)
      PCS_SEQ: npc_o = pc4;
      PCS_JR: begin
        npc_o      = {rs_data_i[31:2], 2'b00};
        misalign_o = (rs_data_i[1:0] != 2'b00);
      end
      PCS_BR:  npc_o = pc4 + br_offset(inst_i[15:0]);
      PCS_J:   npc_o = j_target(pc4[31:28], inst_i);
      default: npc_o = pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack with timeout retry,
// instruction register, and next-PC update driven by the decoder's PC_s.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  Inst_code,
  output logic         inst_valid,
  input  logic [1:0]   PC_s,
  input  logic [31:0]  rs_data,
  input  logic         stall,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic         fetch_err,
  output logic         misalign_err,
  output fetch_state_t fsm_state
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   npc;
  logic          misalign;

  npc_calc u_npc_calc (
    .pc_i       (pc_q),
    .inst_i     (inst_q[25:0]),
    .rs_data_i  (rs_data),
    .pc_s_i     (PC_s),
    .npc_o      (npc),
    .misalign_o (misalign)
  );

  // Handshake: imem_req stays high until the cycle imem_ack is seen; the ack
  // cycle is the transfer. Acks outside S_FETCH are ignored.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    cnt_d        = cnt_q;
    imem_req     = 1'b0;
    inst_valid   = 1'b0;
    fetch_err    = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        // req is gated by rst so an async reset drops it without a clock edge
        imem_req = !rst;
        if (imem_ack) begin
          inst_d  = imem_rdata;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          fetch_err = !rst;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        cnt_d      = '0;
        if (!stall) begin
          pc_d         = npc;
          misalign_err = misalign;
          state_d      = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign Inst_code = inst_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed fetch/exec transactions with a scoreboard
// of expected fetch addresses and instructions checked by a negedge monitor.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic [31:0]  Inst_code;
  logic         inst_valid;
  logic [1:0]   PC_s = PCS_SEQ;
  logic [31:0]  rs_data = '0;
  logic         stall = 1'b0;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         fetch_err;
  logic         misalign_err;
  fetch_state_t fsm_state;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ma_cnt = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Inst_code    (Inst_code),
    .inst_valid   (inst_valid),
    .PC_s         (PC_s),
    .rs_data      (rs_data),
    .stall        (stall),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_err    (fetch_err),
    .misalign_err (misalign_err),
    .fsm_state    (fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=no_finish req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  // monitor: pops expected address on each new request, expected instruction
  // on each entry to exec, and checks that error pulses last one cycle
  logic req_prev = 1'b0, valid_prev = 1'b0, fe_prev = 1'b0, ma_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      req_prev   = 1'b0;
      valid_prev = 1'b0;
      fe_prev    = 1'b0;
      ma_prev    = 1'b0;
    end else begin
      if (imem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) check("addr_q_empty", imem_addr, 32'hFFFF_FFFF);
        else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (inst_valid && !valid_prev) begin
        if (exp_inst_q.size() == 0) check("inst_q_empty", Inst_code, 32'hFFFF_FFFF);
        else check("inst_code", Inst_code, exp_inst_q.pop_front());
      end
      if (fetch_err) begin
        fe_cnt++;
        if (fe_prev) check("fetch_err_width", 32'(fetch_err), 32'd0);
      end
      if (misalign_err) begin
        ma_cnt++;
        if (ma_prev) check("misalign_width", 32'(misalign_err), 32'd0);
      end
      req_prev   = imem_req;
      valid_prev = inst_valid;
      fe_prev    = fetch_err;
      ma_prev    = misalign_err;
    end
  end

  // driver: act as memory for one fetch, then drive the decoder inputs in exec
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int delay,
                       input logic [1:0] pcs, input logic [31:0] rs, input int nstall,
                       input logic [31:0] nxt, input logic exp_ma);
    int n = 0;
    while (!imem_req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_wait", 32'(imem_req), 32'd1);
    check("req_addr", imem_addr, addr);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("retry_req", 32'(imem_req), 32'd1);
      check("retry_addr", imem_addr, addr);
    end
    exp_inst_q.push_back(data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    PC_s    = pcs;
    rs_data = rs;
    stall   = (nstall > 0);
    check("exec_state", 32'(fsm_state), 32'(S_EXEC));
    check("exec_pc", pc, addr);
    check("exec_link", pc_plus4, addr + 32'd4);
    for (int i = 0; i < nstall; i++) begin
      if (i == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      check("stall_pc", pc, addr);
      check("stall_inst", Inst_code, data);
      check("stall_valid", 32'(inst_valid), 32'd1);
    end
    stall = 1'b0;
    exp_addr_q.push_back(nxt);
    #1;
    check("misalign", 32'(misalign_err), 32'(exp_ma));
    @(posedge clk); #1;
    PC_s    = PCS_SEQ;
    rs_data = '0;
    check("npc", pc, nxt);
  endtask

  initial begin
    int fe_before;
    int ma_before;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_inst", Inst_code, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_errs", {30'd0, fetch_err, misalign_err}, 32'd0);
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    #1;
    check("rel_req", 32'(imem_req), 32'd1);

    fetch(32'h0000_0000, 32'h2002_0005, 0, PCS_SEQ, 32'h0,         0, 32'h0000_0004, 1'b0);
    fetch(32'h0000_0004, 32'h03E0_0008, 0, PCS_JR,  32'h0000_0010, 0, 32'h0000_0010, 1'b0);
    fetch(32'h0000_0010, 32'h1042_FFFE, 0, PCS_BR,  32'h0,         0, 32'h0000_000C, 1'b0);
    fetch(32'h0000_000C, 32'h0000_0000, 0, PCS_SEQ, 32'h0,         0, 32'h0000_0010, 1'b0);
    fetch(32'h0000_0010, 32'h1042_FFFE, 0, PCS_SEQ, 32'h0,         0, 32'h0000_0014, 1'b0);
    fetch(32'h0000_0014, 32'h03E0_0008, 0, PCS_JR,  32'h1000_0040, 0, 32'h1000_0040, 1'b0);
    fetch(32'h1000_0040, 32'h0800_0100, 0, PCS_J,   32'h0,         0, 32'h1000_0400, 1'b0);
    ma_before = ma_cnt;
    fetch(32'h1000_0400, 32'h03E0_0008, 0, PCS_JR,  32'h0000_0203, 0, 32'h0000_0200, 1'b1);
    check("misalign_count", 32'(ma_cnt - ma_before), 32'd1);
    fetch(32'h0000_0200, 32'h03E0_0008, 0, PCS_JR,  32'h0000_0200, 0, 32'h0000_0200, 1'b0);
    fe_before = fe_cnt;
    fetch(32'h0000_0200, 32'h0000_0000, 19, PCS_SEQ, 32'h0,        3, 32'h0000_0204, 1'b0);
    check("timeout_count", 32'(fe_cnt - fe_before), 32'd1);
    fetch(32'h0000_0204, 32'h0000_0000, 0, PCS_JR,  32'h0000_0040, 0, 32'h0000_0040, 1'b0);

    // async reset between edges while fetching at 0x40
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_inst", Inst_code, 32'h0);
    check("arst_valid", 32'(inst_valid), 32'd0);
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    fetch(32'h0000_0000, 32'h2002_0005, 0, PCS_SEQ, 32'h0, 0, 32'h0000_0004, 1'b0);

    repeat (2) @(negedge clk);
    check("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
    check("inst_q_left", 32'(exp_inst_q.size()), 32'd0);
    check("fe_total", 32'(fe_cnt), 32'd1);
    check("ma_total", 32'(ma_cnt), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
